// File: rtl/input_stream_buffer.sv
// Byte-addressed image input buffer: LANES interleaved byte banks, byte-enabled writes,
// and an unaligned valid/ready streaming read with optional zero padding past the image.
module input_stream_buffer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned PAD_MODE  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [8*LANES-1:0] wr_data,
  input  logic [LANES-1:0]   wr_be,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [15:0]        cmd_beats,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
  localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [7:0]              mem [DEPTH];
  logic [7:0]              rd_bank_q [LANES];
  logic [ADDR_W-1:0]       bank_addr [LANES];

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [15:0]             beats_left_q, beats_left_d;
  logic                    inflight_q, inflight_d;
  logic                    rd_last_q, rd_last_d;
  logic [LANE_W-1:0]       rot_q, rot_d;
  logic [LANES-1:0]        pad_q, pad_d;
  logic [1:0][8*LANES-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]              fifo_last_q, fifo_last_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    pop, issue;
  logic [2:0]              occ_after;
  logic [ADDR_W:0]         unwrapped;
  logic [8*LANES-1:0]      rd_word;

  assign cmd_ready = (state_q == ST_IDLE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    beats_left_d = beats_left_q;
    inflight_d   = 1'b0;
    rd_last_d    = rd_last_q;
    rot_d        = rot_q;
    pad_d        = pad_q;
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    unwrapped    = '0;

    pop       = out_valid && out_ready;
    occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == ST_RUN) && (occ_after < 3'd2);

    // Each bank serves the one byte of [addr, addr+LANES) that falls in it.
    for (int b = 0; b < LANES; b++)
      bank_addr[b] = rd_addr_q + ((ADDR_W'(b) - rd_addr_q) & LANE_MASK);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_beats != 16'd0) begin
          state_d      = ST_RUN;
          rd_addr_d    = cmd_base;
          beats_left_d = cmd_beats;
        end
      end
      ST_RUN: begin
        if (issue) begin
          rd_addr_d    = rd_addr_q + ADDR_W'(LANES);
          beats_left_d = beats_left_q - 16'd1;
          if (beats_left_q == 16'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      inflight_d = 1'b1;
      rd_last_d  = (beats_left_q == 16'd1);
      rot_d      = LANE_W'(rd_addr_q & LANE_MASK);
      for (int i = 0; i < LANES; i++) begin
        unwrapped = {1'b0, rd_addr_q} + (ADDR_W+1)'(i);
        pad_d[i]  = (PAD_MODE != 0) && (32'(unwrapped) >= IMG_PIXELS);
      end
    end

    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = rd_word;
      fifo_last_d[wr_ptr_q] = rd_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  // Rotate bank outputs back into lane order and blank padded lanes.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int b = 0; b < LANES; b++)
        if ((int'(rot_q) + i) % LANES == b) rd_word[8*i +: 8] = rd_bank_q[b];
      if (pad_q[i]) rd_word[8*i +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rot_q        <= '0;
      pad_q        <= '0;
      fifo_data_q  <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      rd_last_q    <= rd_last_d;
      rot_q        <= rot_d;
      pad_q        <= pad_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the byte storage and its read registers are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_en && wr_be[i]) mem[wr_addr + ADDR_W'(i)] <= wr_data[8*i +: 8];
    // NOTE: non-blocking updates let a same-cycle read see the pre-write byte.
    if (issue)
      for (int b = 0; b < LANES; b++) rd_bank_q[b] <= mem[bank_addr[b]];
  end

endmodule

// File: tb/tb_input_stream_buffer.sv
// Self-checking bench for input_stream_buffer: a plain and a padded (4x4 image) instance
// share all stimulus; expectations come from a byte-array model of the memory.
module tb_input_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, cmd_valid, out_ready;
  logic [15:0] wr_addr, cmd_base, cmd_beats;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        cmd_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic        p_cmd_ready, p_out_valid, p_out_last;
  logic [31:0] p_out_data;

  always #5 clk = ~clk;

  input_stream_buffer #(.ADDR_W(16), .LANES(4), .IMG_W(64), .IMG_H(64), .PAD_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_beats(cmd_beats), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last));

  input_stream_buffer #(.ADDR_W(16), .LANES(4), .IMG_W(4), .IMG_H(4), .PAD_MODE(1)) dut_pad (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .cmd_valid(cmd_valid), .cmd_ready(p_cmd_ready), .cmd_base(cmd_base),
    .cmd_beats(cmd_beats), .out_valid(p_out_valid), .out_ready(out_ready),
    .out_data(p_out_data), .out_last(p_out_last));

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [65536];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pad_q[$];
  int          first_valid_cyc;
  int          end_cyc;
  bit          side_wr = 0;
  int          side_addr;
  logic [31:0] side_data;
  logic [3:0]  side_be;

  typedef struct {
    int          base;
    int          beats;
    int          rmode;   // 0 = ready always, 2 = fixed 1,0,0,1,0,1 pattern
    logic [31:0] w0, w1, w2;
  } vec_t;
  vec_t vt[3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic void model_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[(addr + i) % 65536] = data[8*i +: 8];
  endfunction

  // Byte i of a beat is the byte at beat_addr+i; with padding, unwrapped addresses >= 16 read 0.
  function automatic logic [31:0] model_word(input int beat_addr, input bit pad);
    logic [31:0] w;
    int ua;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      ua = beat_addr + i;
      if (!(pad && ua >= 16)) w[8*i +: 8] = ref_mem[ua % 65536];
    end
    return w;
  endfunction

  task automatic expect_from_model(input int base, input int beats);
    int a;
    exp_q.delete();
    exp_pad_q.delete();
    for (int k = 0; k < beats; k++) begin
      a = (base + 4 * k) % 65536;
      exp_q.push_back(model_word(a, 1'b0));
      exp_pad_q.push_back(model_word(a, 1'b1));
    end
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = 16'(addr); wr_data = data; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_be = '0;
    model_write(addr, data, be);
  endtask

  // Issue one command and collect its beats against exp_q / exp_pad_q.
  task automatic run_stream(input int base, input int beats, input int rmode, input string tag);
    int          got;
    int          cyc;
    bit          stalled;
    logic [31:0] held_d, e, ep;
    logic        held_l;
    got = 0; cyc = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    check({tag, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base = 16'(base); cmd_beats = 16'(beats);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (side_wr) begin
      wr_en = 1'b1; wr_addr = 16'(side_addr); wr_data = side_data; wr_be = side_be;
    end
    first_valid_cyc = -1;
    while (got < beats && cyc < 300) begin
      if (cyc == 1 && side_wr) begin
        wr_en = 1'b0; wr_be = '0;
        model_write(side_addr, side_data, side_be);
        side_wr = 0;
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc == 1 || cyc == 2 || cyc == 4) ? 1'b0 : 1'b1;
      endcase
      if (stalled) begin
        check({tag, " stall valid"}, out_valid, 1);
        check({tag, " stall data"}, out_data, held_d);
        check({tag, " stall last"}, out_last, held_l);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        e  = exp_q.pop_front();
        ep = exp_pad_q.pop_front();
        check({tag, " data"}, out_data, e);
        check({tag, " last"}, out_last, (got == beats - 1) ? 1 : 0);
        check({tag, " pad valid"}, p_out_valid, 1);
        check({tag, " pad data"}, p_out_data, ep);
        check({tag, " pad last"}, p_out_last, (got == beats - 1) ? 1 : 0);
        if (got == beats - 1) check({tag, " busy on last"}, cmd_ready, 0);
        got++;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    end_cyc = cyc;
    if (got < beats) check({tag, " beats received (timeout)"}, got, beats);
    check({tag, " cmd_ready after"}, cmd_ready, 1);
    check({tag, " valid after"}, out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 3, 0, 32'h03020100, 32'h07060504, 32'h0B0A0908};
    vt[1] = '{1, 2, 0, 32'h04030201, 32'h08070605, 32'h00000000};
    vt[2] = '{0, 3, 2, 32'h03020100, 32'h07060504, 32'h0B0A0908};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    cmd_valid = 1'b0; cmd_base = '0; cmd_beats = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset out_data", out_data, 0);
    check("reset pad out_valid", p_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 512; a += 4) do_write(a, 32'h0, 4'hF);
    for (int a = 16'hFF00; a < 65536; a += 4) do_write(a, 32'h0, 4'hF);

    // Aligned contents, then table rows: aligned read, unaligned read, backpressure.
    do_write(0, 32'h03020100, 4'hF);
    do_write(4, 32'h07060504, 4'hF);
    do_write(8, 32'h0B0A0908, 4'hF);
    for (int r = 0; r < 3; r++) begin
      exp_q.delete(); exp_pad_q.delete();
      exp_q.push_back(vt[r].w0); exp_pad_q.push_back(vt[r].w0);
      exp_q.push_back(vt[r].w1); exp_pad_q.push_back(vt[r].w1);
      if (vt[r].beats > 2) begin
        exp_q.push_back(vt[r].w2); exp_pad_q.push_back(vt[r].w2);
      end
      run_stream(vt[r].base, vt[r].beats, vt[r].rmode, $sformatf("vec%0d", r));
      check($sformatf("vec%0d first valid cycle", r), first_valid_cyc, 2);
      if (vt[r].rmode == 0)
        check($sformatf("vec%0d back-to-back end", r), end_cyc, 2 + vt[r].beats);
    end

    // Padding past a 4x4 image, and read wrap across the top of memory.
    do_write(14, 32'h00000F0E, 4'b0011);
    do_write(16, 32'h000000AA, 4'b0001);
    exp_q = '{32'h00AA0F0E}; exp_pad_q = '{32'h00000F0E};
    run_stream(14, 1, 0, "pad14");
    do_write(16'hFFFE, 32'h44332211, 4'hF);
    exp_q = '{32'h44332211}; exp_pad_q = '{32'h00000000};
    run_stream(16'hFFFE, 1, 0, "wrap");

    // Partial write, then a read of byte 0x103 in the same cycle it is written.
    do_write(16'h102, 32'hDDCCBBAA, 4'b0101);
    exp_q = '{32'h00CC00AA}; exp_pad_q = '{32'h0};
    run_stream(16'h102, 1, 0, "partial");
    side_wr = 1; side_addr = 16'h103; side_data = 32'h000000EE; side_be = 4'b0001;
    exp_q = '{32'h0000CC00}; exp_pad_q = '{32'h0};
    run_stream(16'h103, 1, 0, "rd_old");
    exp_q = '{32'h0000CCEE}; exp_pad_q = '{32'h0};
    run_stream(16'h103, 1, 0, "rd_new");

    // Reset after the first of four beats.
    cmd_valid = 1'b1; cmd_base = 16'h0; cmd_beats = 16'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst beat0 valid", out_valid, 1);
    check("midrst beat0 data", out_data, 32'h03024433);
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_last", out_last, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    out_ready = 1'b1;
    exp_q = '{32'h03024433}; exp_pad_q = '{32'h03024433};
    run_stream(0, 1, 0, "post_rst");

    // Zero-beat command is a no-op.
    cmd_valid = 1'b1; cmd_base = 16'h0; cmd_beats = 16'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("zero beats cmd_ready", cmd_ready, 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("zero beats no output %0d", c), out_valid, 0);
      @(posedge clk); #1;
    end

    // Randomized writes and commands with random backpressure.
    for (int t = 0; t < 30; t++) begin
      int base;
      int beats;
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        do_write($urandom_range(0, 300), $urandom, 4'($urandom_range(0, 15)));
      base  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFFE0, 16'hFFFF))
                                          : int'($urandom_range(0, 300));
      beats = $urandom_range(1, 6);
      expect_from_model(base, beats);
      run_stream(base, beats, 1, $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
